// File: rtl/mdu_ctrl_if.sv
// E-stage multiply/divide bundle: operation request from the pipeline,
// status and HI/LO back to it.
`timescale 1ns/1ps
interface mdu_ctrl_if;
    logic [3:0]  md_op_E;
    logic        valid_E;
    logic [31:0] a_E;
    logic [31:0] b_E;
    logic        md_use_D;
    logic        start;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_op_E, valid_E, a_E, b_E, md_use_D,
        input  start, busy, stall_md, hi, lo
    );

    modport slave (
        input  md_op_E, valid_E, a_E, b_E, md_use_D,
        output start, busy, stall_md, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Fixed-latency multiply/divide sequencer that owns HI/LO; busy and stall_md
// hold MDU users in D until a running operation has written its result.
`timescale 1ns/1ps
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_ctrl_if.slave md
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        accept;
    logic [63:0] prod_s, prod_u;
    logic        signed_div;
    logic [31:0] a_mag, b_mag, num, den, q_raw, r_raw, quo, rem;
    logic [31:0] res_hi, res_lo;
    logic        res_we;

    // Results depend only on the latched operands, never on a_E/b_E during RUN.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    assign signed_div = (op_q == OP_DIV);
    assign a_mag = a_q[31] ? -a_q : a_q;
    assign b_mag = b_q[31] ? -b_q : b_q;
    assign num   = signed_div ? a_mag : a_q;
    assign den   = signed_div ? b_mag : b_q;
    assign q_raw = num / den;
    assign r_raw = num % den;
    assign quo   = (signed_div && (a_q[31] ^ b_q[31])) ? -q_raw : q_raw;
    assign rem   = (signed_div && a_q[31]) ? -r_raw : r_raw;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        res_hi = hi_q;
        res_lo = lo_q;
        res_we = 1'b0;
        case (op_q)
            OP_MULT:  begin {res_hi, res_lo} = prod_s; res_we = 1'b1; end
            OP_MULTU: begin {res_hi, res_lo} = prod_u; res_we = 1'b1; end
            OP_DIV, OP_DIVU: begin
                res_hi = rem;
                res_lo = quo;
                res_we = (b_q != 32'd0);
            end
            default: ;
        endcase
    end

    assign accept      = (state_q == IDLE) && md.valid_E;
    assign md.start    = accept && (md.md_op_E inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
    assign md.busy     = (cnt_q != 4'd0);
    assign md.stall_md = md.md_use_D && (md.start || md.busy);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (md.start) begin
                    op_d    = md.md_op_E;
                    a_d     = md.a_E;
                    b_d     = md.b_E;
                    cnt_d   = (md.md_op_E inside {OP_MULT, OP_MULTU}) ? MULT_LOAD : DIV_LOAD;
                    state_d = RUN;
                end else if (accept && md.md_op_E == OP_MTHI) begin
                    hi_d = md.a_E;
                end else if (accept && md.md_op_E == OP_MTLO) begin
                    lo_d = md.a_E;
                end
            end
            RUN: begin
                if (cnt_q == 4'd1) begin
                    if (res_we) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: latched operands are reset too, so an aborted op leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver queues expected HI/LO and completion
// cycle per mult/div; a monitor checks them when busy falls.
`timescale 1ns/1ps
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    mdu_ctrl_if md();

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a completed mult/div shows up as busy falling.
    always @(posedge clk) begin
        #2;
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !md.busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", 32'(md.busy), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check("result_hi", md.hi, mon_e.hi);
                    check("result_lo", md.lo, mon_e.lo);
                    check("done_cycle", cyc, mon_e.done);
                end
            end
            prev_busy = md.busy;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        md.md_op_E  = 4'd0;
        md.valid_E  = 1'b0;
        md.a_E      = 32'd0;
        md.b_E      = 32'd0;
        md.md_use_D = 1'b0;
    endtask

    // Presents one valid op for a single cycle; mult/div ops queue their expectation.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        int  n;
        bit  is_start;
        md.md_op_E = op;
        md.valid_E = 1'b1;
        md.a_E     = a;
        md.b_E     = b;
        #1;
        is_start = (op >= 4'd1 && op <= 4'd4);
        check("start", 32'(md.start), 32'(is_start));
        check("stall_at_issue", 32'(md.stall_md), 32'(is_start && md.md_use_D));
        if (is_start) begin
            n = (op <= 4'd2) ? MULT_N : DIV_N;
            sb.push_back('{hi: eh, lo: el, done: cyc + n + 1});
        end
        next_cycle();
        md.md_op_E = 4'd0;
        md.valid_E = 1'b0;
    endtask

    task automatic run_busy(input int n, input bit scramble);
        for (int i = 0; i < n; i++) begin
            #1;
            check("busy_run", 32'(md.busy), 32'd1);
            if (md.md_use_D) check("stall_run", 32'(md.stall_md), 32'd1);
            if (scramble) begin
                md.a_E = $urandom;
                md.b_E = $urandom;
            end
            next_cycle();
        end
        #1;
        check("busy_done", 32'(md.busy), 32'd0);
        check("stall_done", 32'(md.stall_md), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(md.busy), 32'd0);
        check("reset_hi", md.hi, 32'd0);
        check("reset_lo", md.lo, 32'd0);
        check("reset_start", 32'(md.start), 32'd0);
        check("reset_stall", 32'(md.stall_md), 32'd0);
        md.md_use_D = 1'b1;
        #1;
        check("idle_stall_use", 32'(md.stall_md), 32'd0);
        md.md_use_D = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        next_cycle();

        // Signed mult with D-stage user held and operands scrambled during RUN.
        md.md_use_D = 1'b1;
        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_busy(MULT_N, 1'b1);
        md.md_use_D = 1'b0;

        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_busy(MULT_N, 1'b0);

        // div then divu back to back in cycle k+N+1.
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_busy(DIV_N, 1'b0);
        issue(4'd4, 32'd7, 32'd2, 32'd1, 32'd3);
        run_busy(DIV_N, 1'b0);

        // mthi/mtlo visible next cycle, no stall for a same-cycle mfhi in D.
        md.md_use_D = 1'b1;
        issue(4'd5, 32'h1234_5678, 32'd0, 32'd0, 32'd0);
        #1;
        check("mthi_hi", md.hi, 32'h1234_5678);
        check("mthi_busy", 32'(md.busy), 32'd0);
        issue(4'd6, 32'hCAFE_BABE, 32'd0, 32'd0, 32'd0);
        #1;
        check("mtlo_lo", md.lo, 32'hCAFE_BABE);
        check("mtlo_hi_kept", md.hi, 32'h1234_5678);
        md.md_use_D = 1'b0;

        issue(4'd3, 32'd5, 32'd0, 32'h1234_5678, 32'hCAFE_BABE);
        run_busy(DIV_N, 1'b0);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_busy(DIV_N, 1'b0);

        // mfhi, masked mult and out-of-range op change nothing.
        issue(4'd7, 32'hDEAD_BEEF, 32'd1, 32'd0, 32'd0);
        #1;
        check("mfhi_busy", 32'(md.busy), 32'd0);
        check("mfhi_lo_kept", md.lo, 32'h8000_0000);
        md.md_op_E  = 4'd1;
        md.valid_E  = 1'b0;
        md.a_E      = 32'd9;
        md.b_E      = 32'd9;
        md.md_use_D = 1'b1;
        #1;
        check("masked_start", 32'(md.start), 32'd0);
        check("masked_stall", 32'(md.stall_md), 32'd0);
        next_cycle();
        check("masked_busy", 32'(md.busy), 32'd0);
        md.md_use_D = 1'b0;
        md.md_op_E  = 4'd9;
        md.valid_E  = 1'b1;
        #1;
        check("op9_start", 32'(md.start), 32'd0);
        next_cycle();
        check("op9_busy", 32'(md.busy), 32'd0);
        idle_inputs();

        // Asynchronous reset in cycle 3 of a div discards it.
        issue(4'd5, 32'hA5A5_A5A5, 32'd0, 32'd0, 32'd0);
        md.md_op_E = 4'd3;
        md.valid_E = 1'b1;
        md.a_E     = 32'd100;
        md.b_E     = 32'd7;
        #1;
        check("rst_div_start", 32'(md.start), 32'd1);
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
        check("rst_div_busy", 32'(md.busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(md.busy), 32'd0);
        check("async_rst_hi", md.hi, 32'd0);
        check("async_rst_lo", md.lo, 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (DIV_N + 3) next_cycle();
        check("post_rst_busy", 32'(md.busy), 32'd0);
        check("post_rst_hi", md.hi, 32'd0);
        check("post_rst_lo", md.lo, 32'd0);

        issue(4'd1, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
        run_busy(MULT_N, 1'b0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) next_cycle();
        check("sb_drain", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
